// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RISC-V control FSM with memory-ack timeout and retire counter.
// Define MC_CTRL_BNE_EN to accept BNE alongside BEQ.
module mc_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifetch_ack,
  input  logic             mem_ack,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  output logic             IMemRead,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] TO_LAST =
    WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e           r_state;
  state_e           w_next;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_ret;
  logic             r_ill;
  logic             r_to;

  logic w_r, w_i, w_lw, w_sw, w_beq, w_bne, w_br;
  logic w_legal, w_take, w_iack, w_wait_exp;
  logic w_ill_set, w_to_set, w_retire;
  logic w_unused;

  assign w_unused = ^funct7;

  assign w_r   = (opcode == OP_R);
  assign w_i   = (opcode == OP_I);
  assign w_lw  = (opcode == OP_LW);
  assign w_sw  = (opcode == OP_SW);
  assign w_beq = (opcode == OP_BR) && (funct3 == 3'b000);
`ifdef MC_CTRL_BNE_EN
  assign w_bne = (opcode == OP_BR) && (funct3 == 3'b001);
`else
  assign w_bne = 1'b0;
`endif
  assign w_br    = w_beq | w_bne;
  assign w_legal = w_r | w_i | w_lw | w_sw | w_br;
  assign w_take  = w_bne ? ~zero : zero;

  // keep IRWrite/PCWrite low while reset holds the FSM in FETCH
  assign w_iack     = ifetch_ack & ~reset;
  assign w_wait_exp = (TIMEOUT_CYCLES != 0) && (r_wait == TO_LAST);

  always_comb begin
    w_next    = r_state;
    w_ill_set = 1'b0;
    w_to_set  = 1'b0;
    IMemRead  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrc    = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        IMemRead = 1'b1;
        if (w_iack) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_wait_exp) begin
          w_next   = S_TRAP;
          w_to_set = 1'b1;
        end
      end
      S_DECODE: begin
        w_next    = w_legal ? S_EXEC : S_TRAP;
        w_ill_set = ~w_legal;
      end
      S_EXEC: begin
        unique case (1'b1)
          w_r: begin
            ALUOp  = 2'b10;
            w_next = S_WB;
          end
          w_i: begin
            ALUSrc = 1'b1;
            ALUOp  = 2'b10;
            w_next = S_WB;
          end
          (w_lw | w_sw): begin
            ALUSrc = 1'b1;
            w_next = S_MEM;
          end
          w_br: begin
            ALUOp   = 2'b01;
            Branch  = 1'b1;
            PCWrite = w_take;
            w_next  = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        MemRead  = w_lw;
        MemWrite = w_sw;
        if (mem_ack) begin
          w_next = w_lw ? S_WB : S_FETCH;
        end else if (w_wait_exp) begin
          w_next   = S_TRAP;
          w_to_set = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = w_lw;
        w_next   = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_EXEC) ||
                     (r_state == S_MEM)  ||
                     (r_state == S_WB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_ret   <= '0;
      r_ill   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH) ||
                   (r_state == S_MEM)) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_retire) r_ret <= r_ret + 1'b1;
      r_ill <= r_ill | w_ill_set;
      r_to  <= r_to | w_to_set;
    end
  end

  assign state      = r_state;
  assign retire_cnt = r_ret;
  assign illegal    = r_ill;
  assign timeout    = r_to;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for mc_ctrl_fsm (TIMEOUT_CYCLES=4, CNT_W=3).
module tb_mc_ctrl_fsm;

  localparam int TO = 4;
  localparam int CW = 3;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2;
  localparam logic [2:0] M = 3'd3, W = 3'd4, T = 3'd5;

  localparam logic [10:0] C_F  = 11'b100_0000_0000;
  localparam logic [10:0] C_FA = 11'b111_0000_0000;
  localparam logic [10:0] C_0  = 11'b000_0000_0000;
  localparam logic [10:0] C_ER = 11'b000_0000_0010;
  localparam logic [10:0] C_EI = 11'b000_0000_1010;
  localparam logic [10:0] C_EM = 11'b000_0000_1000;
  localparam logic [10:0] C_BT = 11'b001_0000_0101;
  localparam logic [10:0] C_BN = 11'b000_0000_0101;
  localparam logic [10:0] C_ML = 11'b000_1000_0000;
  localparam logic [10:0] C_MS = 11'b000_0100_0000;
  localparam logic [10:0] C_WR = 11'b000_0010_0000;
  localparam logic [10:0] C_WL = 11'b000_0011_0000;

  typedef struct {
    string          tag;
    logic [2:0]     st;
    logic [10:0]    ctl;
    logic           ill;
    logic           to;
    logic [CW-1:0]  ret;
  } exp_t;

  logic clk, reset, ifetch_ack, mem_ack, zero;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic IMemRead, IRWrite, PCWrite, MemRead, MemWrite;
  logic RegWrite, MemtoReg, ALUSrc, Branch;
  logic [1:0] ALUOp;
  logic illegal, timeout;
  logic [2:0] state;
  logic [CW-1:0] retire_cnt;

  exp_t          sbq[$];
  logic [CW-1:0] exp_ret;
  logic [2:0]    prev_st;
  int            errors;
  int            checks;

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ifetch_ack(ifetch_ack), .mem_ack(mem_ack),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero),
    .IMemRead(IMemRead), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .Branch(Branch),
    .ALUOp(ALUOp), .illegal(illegal), .timeout(timeout),
    .state(state), .retire_cnt(retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input string tag, input logic ia, input logic ma,
                      input logic zr, input logic [2:0] st,
                      input logic [10:0] ctl, input logic ill,
                      input logic to);
    exp_t e;
    exp_t o;
    ifetch_ack = ia;
    mem_ack    = ma;
    zero       = zr;
    if (reset) exp_ret = '0;
    else if (st == F && (prev_st == E || prev_st == M || prev_st == W))
      exp_ret = exp_ret + 1'b1;
    prev_st = reset ? F : st;
    e = '{tag, st, ctl, ill, to, exp_ret};
    sbq.push_back(e);
    #2;
    o = sbq.pop_front();
    checks++;
    assert ({state, IMemRead, IRWrite, PCWrite, MemRead, MemWrite,
             RegWrite, MemtoReg, ALUSrc, Branch, ALUOp,
             illegal, timeout, retire_cnt} ===
            {o.st, o.ctl, o.ill, o.to, o.ret})
    else begin
      errors++;
      $error("FAIL %s: got st=%0d ctl=%b ill=%b to=%b ret=%0d want st=%0d ctl=%b ill=%b to=%b ret=%0d",
             o.tag, state,
             {IMemRead, IRWrite, PCWrite, MemRead, MemWrite, RegWrite,
              MemtoReg, ALUSrc, Branch, ALUOp},
             illegal, timeout, retire_cnt,
             o.st, o.ctl, o.ill, o.to, o.ret);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step(tag, 1'b1, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);
    step(tag, 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic ins(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  task automatic fetch_dec(input string tag);
    step({tag, "_if"}, 1'b1, 1'b0, 1'b0, F, C_FA, 1'b0, 1'b0);
    step({tag, "_id"}, 1'b0, 1'b0, 1'b0, D, C_0, 1'b0, 1'b0);
  endtask

  task automatic beq(input logic zr);
    ins(7'b1100011, 3'b000);
    fetch_dec("beq");
    step("beq_ex", 1'b0, 1'b0, zr, E, zr ? C_BT : C_BN, 1'b0, 1'b0);
    step("beq_if", 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_ret = '0;
    prev_st = F;
    reset = 1'b1;
    ifetch_ack = 1'b0;
    mem_ack = 1'b0;
    zero = 1'b0;
    funct7 = 7'd0;
    ins(7'b0110011, 3'b000);
    @(negedge clk);
    do_reset("reset");

    fetch_dec("add");
    step("add_ex", 1'b0, 1'b0, 1'b0, E, C_ER, 1'b0, 1'b0);
    step("add_wb", 1'b0, 1'b0, 1'b0, W, C_WR, 1'b0, 1'b0);
    step("add_if", 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);

    ins(7'b0000011, 3'b010);
    fetch_dec("lw");
    step("lw_ex", 1'b0, 1'b0, 1'b0, E, C_EM, 1'b0, 1'b0);
    step("lw_m1", 1'b0, 1'b0, 1'b0, M, C_ML, 1'b0, 1'b0);
    step("lw_m2", 1'b0, 1'b0, 1'b0, M, C_ML, 1'b0, 1'b0);
    step("lw_m3", 1'b0, 1'b1, 1'b0, M, C_ML, 1'b0, 1'b0);
    step("lw_wb", 1'b0, 1'b0, 1'b0, W, C_WL, 1'b0, 1'b0);
    step("lw_if", 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);

    ins(7'b0010011, 3'b000);
    fetch_dec("addi");
    step("addi_ex", 1'b0, 1'b0, 1'b0, E, C_EI, 1'b0, 1'b0);
    step("addi_wb", 1'b0, 1'b0, 1'b0, W, C_WR, 1'b0, 1'b0);
    step("addi_if", 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);

    beq(1'b1);
    beq(1'b0);

    ins(7'b0100011, 3'b010);
    fetch_dec("sw");
    step("sw_ex", 1'b0, 1'b0, 1'b0, E, C_EM, 1'b0, 1'b0);
    step("sw_m1", 1'b0, 1'b0, 1'b0, M, C_MS, 1'b0, 1'b0);
    step("sw_m2", 1'b0, 1'b0, 1'b0, M, C_MS, 1'b0, 1'b0);
    step("sw_m3", 1'b0, 1'b0, 1'b0, M, C_MS, 1'b0, 1'b0);
    step("sw_m4ack", 1'b0, 1'b1, 1'b0, M, C_MS, 1'b0, 1'b0);
    step("sw_if", 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);

    beq(1'b1);
    beq(1'b0);

    ins(7'b1100011, 3'b001);
    fetch_dec("bne");
`ifdef MC_CTRL_BNE_EN
    step("bne_ex", 1'b0, 1'b0, 1'b0, E, C_BT, 1'b0, 1'b0);
    step("bne_if", 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);
`else
    step("bne_trap", 1'b0, 1'b0, 1'b0, T, C_0, 1'b1, 1'b0);
    do_reset("bne_rst");
`endif

    ins(7'b1110011, 3'b000);
    fetch_dec("ecall");
    for (int i = 0; i < 20; i++)
      step("ecall_trap", 1'b1, 1'b1, 1'b1, T, C_0, 1'b1, 1'b0);
    do_reset("ecall_rst");

    ins(7'b0100011, 3'b010);
    fetch_dec("swto");
    step("swto_ex", 1'b0, 1'b0, 1'b0, E, C_EM, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++)
      step("swto_mem", 1'b0, 1'b0, 1'b0, M, C_MS, 1'b0, 1'b0);
    step("swto_trap", 1'b0, 1'b1, 1'b0, T, C_0, 1'b0, 1'b1);
    step("swto_hold", 1'b1, 1'b1, 1'b0, T, C_0, 1'b0, 1'b1);
    do_reset("swto_rst");

    ins(7'b0000011, 3'b010);
    fetch_dec("lwab");
    step("lwab_ex", 1'b0, 1'b0, 1'b0, E, C_EM, 1'b0, 1'b0);
    step("lwab_m1", 1'b0, 1'b0, 1'b0, M, C_ML, 1'b0, 1'b0);
    step("lwab_m2", 1'b0, 1'b0, 1'b0, M, C_ML, 1'b0, 1'b0);
    reset = 1'b1;
    step("lwab_rst", 1'b0, 1'b1, 1'b0, F, C_F, 1'b0, 1'b0);
    reset = 1'b0;
    step("lwab_if", 1'b0, 1'b0, 1'b0, F, C_F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum wait cycles for a memory ack; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 16, is the width of the retired-instruction counter.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ifetch_ack  in  1  instruction memory returns a valid word this cycle.
REQ-006 mem_ack  in  1  data memory completes the pending read or write this cycle.
REQ-007 opcode  in  7, funct3  in  3, funct7  in  7  fields of the instruction register.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 IMemRead, IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, ALUSrc, Branch  out  1 each  datapath controls.
REQ-010 ALUOp  out  2  00 add, 01 sub/compare, 10 decode by funct3/funct7.
REQ-011 illegal  out  1, timeout  out  1  sticky trap causes; state  out  3  current state; retire_cnt  out  CNT_W  completed instructions.

Function
REQ-012 States SHALL be encoded as FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 go to FETCH on the next edge.
REQ-013 Controls not listed for a state SHALL be 0.
REQ-014 FETCH: IMemRead=1; on ifetch_ack, IRWrite=1 and PCWrite=1 in the same cycle and next state is DECODE; otherwise remain in FETCH.
REQ-015 DECODE: 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW) and 1100011 with funct3=000 (BEQ) go to EXEC; any other encoding goes to TRAP and sets illegal.
REQ-016 EXEC, R-type: ALUSrc=0, ALUOp=10; next state WB.
REQ-017 EXEC, I-ALU: ALUSrc=1, ALUOp=10; next state WB.
REQ-018 EXEC, LW/SW: ALUSrc=1, ALUOp=00; next state MEM.
REQ-019 EXEC, BEQ: ALUSrc=0, ALUOp=01, Branch=1, PCWrite=zero; next state FETCH.
REQ-020 MEM, LW: MemRead=1 held until mem_ack, then next state WB.
REQ-021 MEM, SW: MemWrite=1 held until mem_ack, then next state FETCH.
REQ-022 WB: RegWrite=1 for exactly one cycle, MemtoReg=1 only for LW; next state FETCH.
REQ-023 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without an ack.
REQ-024 If TIMEOUT_CYCLES>0 and no ack arrives within TIMEOUT_CYCLES cycles, next state is TRAP and timeout is set; an ack in the final allowed cycle wins.
REQ-025 TRAP: all controls 0; illegal/timeout held; exit only by reset.
REQ-026 retire_cnt SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, and wrap modulo 2^CNT_W.
REQ-027 PCWrite, IRWrite and WB controls depend on the current state and inputs only; no output is registered beyond the state.

Reset
REQ-028 While reset is high: state=FETCH, wait counter=0, retire_cnt=0, illegal=0, timeout=0.
REQ-029 Outputs follow FETCH decode during reset: IMemRead=1, all other controls 0, ALUOp=00.
REQ-030 Reset asserted mid-instruction, including a pending MEM wait, SHALL abort immediately with no further Mem/Reg writes.

Configuration
REQ-031 Macro MC_CTRL_BNE_EN defined: opcode 1100011 with funct3=001 (BNE) is legal, with EXEC as BEQ except PCWrite=~zero.
REQ-032 Macro MC_CTRL_BNE_EN undefined: funct3 other than 000 on opcode 1100011 is illegal per REQ-015.

Verification
REQ-033 Reset, then R-type add with ifetch_ack in the first cycle -> states 0,1,2,4,0; RegWrite=1 one cycle; ALUOp=10 in EXEC; retire_cnt=1.
REQ-034 LW with mem_ack on the 3rd MEM cycle -> MemRead=1 for 3 cycles; WB has MemtoReg=1, RegWrite=1.
REQ-035 BEQ with zero=1 -> Branch=1, PCWrite=1 in EXEC; repeated with zero=0 -> PCWrite=0; both return to FETCH.
REQ-036 Opcode 1110011 -> TRAP, illegal=1, all controls 0 for 20 cycles; reset clears to FETCH.
REQ-037 TIMEOUT_CYCLES=4, SW, mem_ack never asserted -> MemWrite=1 for 4 cycles, then TRAP, timeout=1; ack in the 4th cycle -> FETCH instead.
REQ-038 BNE with funct3=001, zero=0 -> with MC_CTRL_BNE_EN: PCWrite=1; without it: illegal=1.
